// File: rtl/c0_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : c0_read_arbiter (with local CCI-P c0 type package)
//  Purpose  : Shares one CCI-P c0 read channel between NUM_REQ DMA engines.
//             Per-requester request FIFOs, round-robin upstream issue with
//             the requester index tagged into mdata[15:12], and tag-based
//             routing of read responses back to their owners.
//  Revision : 1.0  initial release
// ============================================================================

package c0_arb_ccip_pkg;

    // c0 read request header
    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    // c0 response header
    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

endpackage

module c0_read_arbiter
    import c0_arb_ccip_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int ALMFULL_SLACK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  t_if_ccip_c0_Tx       req_tx [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_almfull,
    output t_if_ccip_c0_Rx       req_rx [NUM_REQ],
    output t_if_ccip_c0_Tx       c0tx,
    input  logic                 c0TxAlmFull,
    input  t_if_ccip_c0_Rx       c0rx,
    output logic                 err_overflow,
    output logic                 err_bad_tag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALMFULL_THR = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);

    t_ccip_c0_ReqMemHdr fifo_mem [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr   [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr   [NUM_REQ];
    logic [CNT_W-1:0]   count    [NUM_REQ];

    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    grant;
    logic               grant_found;
    logic               pop;
    logic [NUM_REQ-1:0] push_ok;
    logic [NUM_REQ-1:0] pop_sel;
    logic               overflow_hit;
    t_ccip_c0_ReqMemHdr issue_hdr;

    logic [3:0]         rsp_tag;
    logic               bad_tag;
    logic               unused_mmio;

    // MMIO strobes from upstream are never forwarded to the engines
    assign unused_mmio = c0rx.mmioRdValid | c0rx.mmioWrValid;

    // Round-robin scan: first non-empty FIFO starting at rr_ptr
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && (count[idx] != '0)) begin
                grant_found = 1'b1;
                grant       = RR_W'(idx);
            end
        end
    end

    assign pop = grant_found && !c0TxAlmFull;

    // Per-FIFO push acceptance, pop select and overflow detection
    always_comb begin
        push_ok      = '0;
        pop_sel      = '0;
        overflow_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_sel[i] = pop && (int'(grant) == i);
            if (req_tx[i].valid) begin
                if (count[i] == FULL_CNT) begin
                    overflow_hit = 1'b1;
                end else begin
                    push_ok[i] = 1'b1;
                end
            end
        end
    end

    // Head of the granted FIFO with the requester index stamped into the tag
    always_comb begin
        issue_hdr             = fifo_mem[grant][rd_ptr[grant]];
        issue_hdr.mdata[15:12] = 4'(grant);
    end

    // FIFO pointers and occupancy counters
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_sel[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push_ok[i] && !pop_sel[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!push_ok[i] && pop_sel[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_ok[i] && !reset) begin
                fifo_mem[i][wr_ptr[i]] <= req_tx[i].hdr;
            end
        end
    end

    // Round-robin pointer advances past the granted requester on each pop
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (pop) begin
            rr_ptr <= RR_W'((int'(grant) + 1) % NUM_REQ);
        end
    end

    // Registered upstream request
    always_ff @(posedge clk) begin
        c0tx.hdr <= issue_hdr;
        if (reset) begin
            c0tx.valid <= 1'b0;
        end else begin
            c0tx.valid <= pop;
        end
    end

    // Registered per-engine backpressure; held high through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            req_almfull <= '1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_almfull[i] <= (count[i] >= ALMFULL_THR);
            end
        end
    end

    assign rsp_tag = c0rx.hdr.mdata[15:12];
    assign bad_tag = c0rx.rspValid && (int'(rsp_tag) >= NUM_REQ);

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow <= 1'b0;
            err_bad_tag  <= 1'b0;
        end else begin
            if (overflow_hit) err_overflow <= 1'b1;
            if (bad_tag)      err_bad_tag  <= 1'b1;
        end
    end

    // Stateless response routing: broadcast payload, tag-decoded valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rx[i].hdr         <= c0rx.hdr;
            req_rx[i].data        <= c0rx.data;
            req_rx[i].mmioRdValid <= 1'b0;
            req_rx[i].mmioWrValid <= 1'b0;
            if (reset) begin
                req_rx[i].rspValid <= 1'b0;
            end else begin
                req_rx[i].rspValid <= c0rx.rspValid && (int'(rsp_tag) == i);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c0_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c0_read_arbiter
//  Purpose  : Self-checking bench for c0_read_arbiter: directed scenarios
//             plus randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c0_read_arbiter;
    import c0_arb_ccip_pkg::*;

    localparam int NUM_REQ       = 4;
    localparam int FIFO_DEPTH    = 8;
    localparam int ALMFULL_SLACK = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    t_if_ccip_c0_Tx       req_tx [NUM_REQ];
    logic [NUM_REQ-1:0]   req_almfull;
    t_if_ccip_c0_Rx       req_rx [NUM_REQ];
    t_if_ccip_c0_Tx       c0tx;
    logic                 c0TxAlmFull;
    t_if_ccip_c0_Rx       c0rx;
    logic                 err_overflow;
    logic                 err_bad_tag;

    int total = 0;
    int bad   = 0;

    // Reference model state
    t_ccip_c0_ReqMemHdr mq [NUM_REQ][$];
    int                 m_rr;
    logic               m_valid;
    t_ccip_c0_ReqMemHdr m_hdr;
    logic [NUM_REQ-1:0] m_almfull;
    logic               m_ovf;
    logic               m_tag;
    logic [NUM_REQ-1:0] m_rxv;
    logic [15:0]        m_rx_mdata;
    logic [511:0]       m_rx_data;

    c0_read_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .ALMFULL_SLACK(ALMFULL_SLACK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_tx      (req_tx),
        .req_almfull (req_almfull),
        .req_rx      (req_rx),
        .c0tx        (c0tx),
        .c0TxAlmFull (c0TxAlmFull),
        .c0rx        (c0rx),
        .err_overflow(err_overflow),
        .err_bad_tag (err_bad_tag)
    );

    always #5 clk = ~clk;

    function automatic t_ccip_c0_ReqMemHdr mk_hdr(input logic [41:0] a, input logic [15:0] md);
        t_ccip_c0_ReqMemHdr h;
        h         = '0;
        h.vc_sel  = 2'd2;
        h.address = a;
        h.mdata   = md;
        return h;
    endfunction

    // Model advances one clock from the inputs currently presented
    task automatic model_step();
        int  sz [NUM_REQ];
        bit  found;
        int  g;
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
            m_rr      = 0;
            m_valid   = 1'b0;
            m_almfull = '1;
            m_ovf     = 1'b0;
            m_tag     = 1'b0;
            m_rxv     = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) sz[i] = mq[i].size();
            for (int i = 0; i < NUM_REQ; i++) m_almfull[i] = (sz[i] >= FIFO_DEPTH - ALMFULL_SLACK);
            m_valid = 1'b0;
            found   = 1'b0;
            if (!c0TxAlmFull) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    g = (m_rr + k) % NUM_REQ;
                    if (!found && sz[g] > 0) begin
                        found               = 1'b1;
                        m_hdr               = mq[g].pop_front();
                        m_hdr.mdata[15:12]  = 4'(g);
                        m_valid             = 1'b1;
                        m_rr                = (g + 1) % NUM_REQ;
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_tx[i].valid) begin
                    if (sz[i] == FIFO_DEPTH) m_ovf = 1'b1;
                    else mq[i].push_back(req_tx[i].hdr);
                end
            end
            for (int i = 0; i < NUM_REQ; i++)
                m_rxv[i] = c0rx.rspValid && (int'(c0rx.hdr.mdata[15:12]) == i);
            if (c0rx.rspValid && int'(c0rx.hdr.mdata[15:12]) >= NUM_REQ) m_tag = 1'b1;
        end
        m_rx_mdata = c0rx.hdr.mdata;
        m_rx_data  = c0rx.data;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) req_tx[i] = '0;
        c0rx = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        c0TxAlmFull = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        c0TxAlmFull = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        total++; if (c0tx.valid !== 1'b0) begin bad++; $display("FAIL reset_c0tx_valid: got %b want 0", c0tx.valid); end
        total++; if (req_almfull !== 4'hF) begin bad++; $display("FAIL reset_almfull: got %h want f", req_almfull); end
        total++; if (err_overflow !== 1'b0 || err_bad_tag !== 1'b0) begin bad++; $display("FAIL reset_err: got %b%b want 00", err_overflow, err_bad_tag); end
        for (int i = 0; i < NUM_REQ; i++) begin
            total++;
            if (req_rx[i].rspValid !== 1'b0 || req_rx[i].mmioRdValid !== 1'b0 || req_rx[i].mmioWrValid !== 1'b0) begin
                bad++; $display("FAIL reset_rx_valid[%0d]: got %b%b%b want 000", i, req_rx[i].rspValid, req_rx[i].mmioRdValid, req_rx[i].mmioWrValid);
            end
        end
        reset = 1'b0;
        tick();
        total++; if (req_almfull !== 4'h0) begin bad++; $display("FAIL reset_almfull_release: got %h want 0", req_almfull); end
    endtask

    task automatic test_single();
        int first;
        int seen;
        do_reset();
        first = -1;
        seen  = 0;
        for (int t = 1; t <= 8; t++) begin
            if (t <= 3) begin
                req_tx[0].valid = 1'b1;
                req_tx[0].hdr   = mk_hdr(42'h100 + 42'(t - 1), 16'hF0A0 + 16'(t));
            end else begin
                req_tx[0].valid = 1'b0;
            end
            tick();
            if (c0tx.valid) begin
                if (first < 0) first = t;
                total++; if (t != first + seen) begin bad++; $display("FAIL single_consecutive: got cycle %0d want %0d", t, first + seen); end
                total++; if (c0tx.hdr.address !== 42'h100 + 42'(seen)) begin bad++; $display("FAIL single_addr: got %h want %h", c0tx.hdr.address, 42'h100 + 42'(seen)); end
                total++; if (c0tx.hdr.mdata !== 16'h00A0 + 16'(seen + 1)) begin bad++; $display("FAIL single_mdata: got %h want %h", c0tx.hdr.mdata, 16'h00A0 + 16'(seen + 1)); end
                seen++;
            end
        end
        total++; if (first != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", first); end
        total++; if (seen != 3) begin bad++; $display("FAIL single_count: got %0d want 3", seen); end
    endtask

    task automatic test_round_robin();
        int ord [8];
        int n;
        int firsttag;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tx[i].valid = 1'b1;
            req_tx[i].hdr   = mk_hdr(42'h200 + 42'(i), 16'h0011);
        end
        tick();
        idle_inputs();
        n = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (c0tx.valid && n < 8) begin
                ord[n] = int'(c0tx.hdr.mdata[15:12]);
                total++; if (c0tx.hdr.address !== 42'h200 + 42'(ord[n])) begin bad++; $display("FAIL rr_addr: got %h want %h", c0tx.hdr.address, 42'h200 + 42'(ord[n])); end
                n++;
            end
        end
        total++; if (n != 4) begin bad++; $display("FAIL rr_count: got %0d want 4", n); end
        for (int k = 0; k < 4; k++) begin
            total++; if (k >= n || ord[k] != k) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, (k < n) ? ord[k] : -1, k); end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tx[i].valid = 1'b1;
            req_tx[i].hdr   = mk_hdr(42'h210 + 42'(i), 16'h0022);
        end
        tick();
        idle_inputs();
        firsttag = -1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (c0tx.valid && firsttag < 0) firsttag = int'(c0tx.hdr.mdata[15:12]);
        end
        total++; if (firsttag != 0) begin bad++; $display("FAIL rr_wrap_first: got %0d want 0", firsttag); end
    endtask

    task automatic test_almfull();
        int n;
        bit any_valid;
        do_reset();
        c0TxAlmFull = 1'b1;
        any_valid   = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            if (t <= 5) begin
                req_tx[1].valid = 1'b1;
                req_tx[1].hdr   = mk_hdr(42'h300 + 42'(t - 1), 16'h0000);
            end else begin
                req_tx[1].valid = 1'b0;
            end
            tick();
            if (c0tx.valid) any_valid = 1'b1;
            if (t == 4) begin
                total++; if (req_almfull !== 4'b0000) begin bad++; $display("FAIL almfull_before: got %b want 0000", req_almfull); end
            end
            if (t == 5) begin
                total++; if (req_almfull !== 4'b0010) begin bad++; $display("FAIL almfull_assert: got %b want 0010", req_almfull); end
            end
        end
        total++; if (any_valid) begin bad++; $display("FAIL almfull_stall_valid: got 1 want 0"); end
        c0TxAlmFull = 1'b0;
        n = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (c0tx.valid) begin
                total++;
                if (c0tx.hdr.address !== 42'h300 + 42'(n) || c0tx.hdr.mdata[15:12] !== 4'd1) begin
                    bad++; $display("FAIL almfull_drain: got %h/%h want %h/1", c0tx.hdr.address, c0tx.hdr.mdata[15:12], 42'h300 + 42'(n));
                end
                n++;
            end
        end
        total++; if (n != 5) begin bad++; $display("FAIL almfull_drain_count: got %0d want 5", n); end
    endtask

    task automatic test_response();
        logic [511:0] d;
        do_reset();
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
        c0rx.rspValid  = 1'b1;
        c0rx.hdr.mdata = 16'h2005;
        c0rx.data      = d;
        tick();
        c0rx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            total++; if (req_rx[i].rspValid !== (i == 2)) begin bad++; $display("FAIL rsp_route[%0d]: got %b want %b", i, req_rx[i].rspValid, (i == 2)); end
            total++; if (req_rx[i].data !== d) begin bad++; $display("FAIL rsp_data[%0d]: got %h want %h", i, req_rx[i].data, d); end
        end
        total++; if (req_rx[2].hdr.mdata[7:0] !== 8'h05) begin bad++; $display("FAIL rsp_mdata: got %h want 05", req_rx[2].hdr.mdata[7:0]); end
        total++; if (err_bad_tag !== 1'b0) begin bad++; $display("FAIL rsp_good_tag_err: got %b want 0", err_bad_tag); end
        c0rx.rspValid  = 1'b1;
        c0rx.hdr.mdata = 16'h7011;
        tick();
        c0rx = '0;
        total++;
        if (req_rx[0].rspValid | req_rx[1].rspValid | req_rx[2].rspValid | req_rx[3].rspValid) begin
            bad++; $display("FAIL rsp_bad_tag_route: got valid want none");
        end
        tick();
        total++; if (err_bad_tag !== 1'b1) begin bad++; $display("FAIL rsp_bad_tag_err: got %b want 1", err_bad_tag); end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        c0TxAlmFull = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            req_tx[0].valid = 1'b1;
            req_tx[0].hdr   = mk_hdr(42'h500 + 42'(t - 1), 16'h0000);
            tick();
            if (t == 8) begin
                total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
            end
        end
        req_tx[0].valid = 1'b0;
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
        c0TxAlmFull = 1'b0;
        n = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (c0tx.valid) begin
                total++; if (c0tx.hdr.address !== 42'h500 + 42'(n)) begin bad++; $display("FAIL ovf_drain: got %h want %h", c0tx.hdr.address, 42'h500 + 42'(n)); end
                n++;
            end
        end
        total++; if (n != 8) begin bad++; $display("FAIL ovf_drain_count: got %0d want 8", n); end
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
    endtask

    task automatic test_reset_mid();
        bit leaked;
        c0TxAlmFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_tx[i].valid = 1'b1;
            req_tx[i].hdr   = mk_hdr(42'h600 + 42'(i), 16'h0000);
        end
        tick();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        total++; if (c0tx.valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", c0tx.valid); end
        total++; if (req_almfull !== 4'hF) begin bad++; $display("FAIL mid_reset_almfull: got %h want f", req_almfull); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_err_clear: got %b want 0", err_overflow); end
        reset          = 1'b0;
        c0TxAlmFull    = 1'b0;
        c0rx.rspValid  = 1'b1;
        c0rx.hdr.mdata = 16'h1033;
        tick();
        c0rx = '0;
        total++; if (req_almfull !== 4'h0) begin bad++; $display("FAIL mid_almfull_release: got %h want 0", req_almfull); end
        total++; if (req_rx[1].rspValid !== 1'b1) begin bad++; $display("FAIL mid_rsp_route: got %b want 1", req_rx[1].rspValid); end
        leaked = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (c0tx.valid) leaked = 1'b1;
        end
        total++; if (leaked) begin bad++; $display("FAIL mid_reset_discard: got issue want none"); end
    endtask

    task automatic test_random();
        logic [95:0]  raw;
        logic [511:0] d;
        int           r;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                raw = {$urandom(), $urandom(), $urandom()};
                req_tx[i].hdr   = raw[$bits(t_ccip_c0_ReqMemHdr)-1:0];
                req_tx[i].valid = req_almfull[i] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            end
            c0TxAlmFull = ($urandom_range(0, 3) == 0);
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
            c0rx.data          = d;
            c0rx.hdr           = t_ccip_c0_RspMemHdr'($urandom());
            c0rx.hdr.mdata     = 16'($urandom());
            c0rx.hdr.mdata[15] = ($urandom_range(0, 19) == 0);
            c0rx.rspValid      = $urandom_range(0, 1) == 1;
            c0rx.mmioRdValid   = $urandom_range(0, 1) == 1;
            c0rx.mmioWrValid   = $urandom_range(0, 1) == 1;
            tick();
            total++; if (c0tx.valid !== m_valid) begin bad++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, c0tx.valid, m_valid); end
            if (m_valid) begin
                total++; if (c0tx.hdr !== m_hdr) begin bad++; $display("FAIL rnd_hdr @%0d: got %h want %h", cyc, c0tx.hdr, m_hdr); end
            end
            total++; if (req_almfull !== m_almfull) begin bad++; $display("FAIL rnd_almfull @%0d: got %b want %b", cyc, req_almfull, m_almfull); end
            total++; if (err_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf @%0d: got %b want %b", cyc, err_overflow, m_ovf); end
            total++; if (err_bad_tag !== m_tag) begin bad++; $display("FAIL rnd_badtag @%0d: got %b want %b", cyc, err_bad_tag, m_tag); end
            for (int i = 0; i < NUM_REQ; i++) begin
                total++;
                if (req_rx[i].rspValid !== m_rxv[i] || req_rx[i].mmioRdValid !== 1'b0 || req_rx[i].mmioWrValid !== 1'b0) begin
                    bad++; $display("FAIL rnd_rx_valid[%0d] @%0d: got %b%b%b want %b00", i, cyc, req_rx[i].rspValid, req_rx[i].mmioRdValid, req_rx[i].mmioWrValid, m_rxv[i]);
                end
            end
            r = $urandom_range(0, NUM_REQ - 1);
            total++; if (req_rx[r].hdr.mdata !== m_rx_mdata) begin bad++; $display("FAIL rnd_rx_mdata[%0d] @%0d: got %h want %h", r, cyc, req_rx[r].hdr.mdata, m_rx_mdata); end
            total++; if (req_rx[r].data !== m_rx_data) begin bad++; $display("FAIL rnd_rx_data[%0d] @%0d: got %h want %h", r, cyc, req_rx[r].data, m_rx_data); end
        end
        idle_inputs();
    endtask

    initial begin
        reset       = 1'b1;
        c0TxAlmFull = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_almfull();
        test_response();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
